dvp_config_regbank: RTL

DVP_CONFIG_REGBANK -- requirements
Module: dvp_config_regbank

---
 rtl/dvp_config_regbank.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dvp_config_regbank.sv
// rtl/dvp_config_regbank.sv - memory-mapped configuration register bank for the DVP block
// Independent AW/W holders feed a single-outstanding write path; the read path runs alongside it.
module dvp_config_regbank #(
   parameter logic [31:0]         BASE_ADDR  = 32'h4000_0000,
   parameter int                  REG_NUM    = 4,
   parameter int                  REG_STRIDE = 4,
   parameter int                  DATA_W     = 32,
   parameter int                  ADDR_W     = 32,
   parameter int                  MST_ID_W   = 5,
   parameter logic [REG_NUM-1:0]  RO_MASK    = '0,
   parameter logic [DATA_W-1:0]   CONF_RST   = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [MST_ID_W-1:0]         m_awid_i,
   input  logic [ADDR_W-1:0]           m_awaddr_i,
   input  logic                        m_awvalid_i,
   output logic                        m_awready_o,
   input  logic [DATA_W-1:0]           m_wdata_i,
   input  logic [DATA_W/8-1:0]         m_wstrb_i,
   input  logic                        m_wvalid_i,
   output logic                        m_wready_o,
   output logic [MST_ID_W-1:0]         m_bid_o,
   output logic [1:0]                  m_bresp_o,
   output logic                        m_bvalid_o,
   input  logic                        m_bready_i,
   input  logic [MST_ID_W-1:0]         m_arid_i,
   input  logic [ADDR_W-1:0]           m_araddr_i,
   input  logic                        m_arvalid_i,
   output logic                        m_arready_o,
   output logic [MST_ID_W-1:0]         m_rid_o,
   output logic [DATA_W-1:0]           m_rdata_o,
   output logic [1:0]                  m_rresp_o,
   output logic                        m_rvalid_o,
   input  logic                        m_rready_i,
   output logic [REG_NUM*DATA_W-1:0]   conf_o,
   input  logic [REG_NUM*DATA_W-1:0]   sts_i,
   output logic [REG_NUM-1:0]          conf_upd_o
);
   localparam int STRB_W = DATA_W / 8;
   localparam int IDX_W  = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

   typedef enum logic {W_IDLE, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_RESP} r_state_e;

   w_state_e                   w_state_q, w_state_d;
   r_state_e                   r_state_q, r_state_d;
   logic                       aw_full_q, aw_full_d;
   logic [MST_ID_W-1:0]        aw_id_q, aw_id_d;
   logic [ADDR_W-1:0]          aw_addr_q, aw_addr_d;
   logic                       w_full_q, w_full_d;
   logic [DATA_W-1:0]          w_data_q, w_data_d;
   logic [STRB_W-1:0]          w_strb_q, w_strb_d;
   logic [REG_NUM*DATA_W-1:0]  conf_q, conf_d, conf_view;
   logic [REG_NUM-1:0]         conf_upd_q, conf_upd_d;
   logic [MST_ID_W-1:0]        bid_q, bid_d;
   logic [1:0]                 bresp_q, bresp_d;
   logic [MST_ID_W-1:0]        rid_q, rid_d;
   logic [DATA_W-1:0]          rdata_q, rdata_d;
   logic [1:0]                 rresp_q, rresp_d;
   logic                       w_hit, r_hit;
   logic [IDX_W-1:0]           w_idx, r_idx;

   function automatic logic [IDX_W:0] decode(input logic [ADDR_W-1:0] addr);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = 0; i < REG_NUM; i++) begin
         if (addr == ADDR_W'(BASE_ADDR) + ADDR_W'(i * REG_STRIDE)) res = {1'b1, IDX_W'(i)};
      end
      return res;
   endfunction

   // Read-only slots expose the live status input instead of their (unused) storage.
   for (genvar g = 0; g < REG_NUM; g++) begin : g_view
      assign conf_view[g*DATA_W +: DATA_W] = RO_MASK[g] ? sts_i[g*DATA_W +: DATA_W]
                                                        : conf_q[g*DATA_W +: DATA_W];
   end

   always_comb begin
      w_state_d  = w_state_q;
      aw_full_d  = aw_full_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      w_full_d   = w_full_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      conf_d     = conf_q;
      conf_upd_d = '0;
      bid_d      = bid_q;
      bresp_d    = bresp_q;
      {w_hit, w_idx} = '0;
      if (m_awvalid_i && !aw_full_q) begin
         aw_full_d = 1'b1;
         aw_id_d   = m_awid_i;
         aw_addr_d = m_awaddr_i;
      end
      if (m_wvalid_i && !w_full_q) begin
         w_full_d = 1'b1;
         w_data_d = m_wdata_i;
         w_strb_d = m_wstrb_i;
      end
      case (w_state_q)
         // Commit on the edge that completes the pair, so B appears the cycle after the last beat.
         W_IDLE: if (aw_full_d && w_full_d) begin
            w_state_d      = W_RESP;
            bid_d          = aw_id_d;
            {w_hit, w_idx} = decode(aw_addr_d);
            if (!w_hit) begin
               bresp_d = 2'b11;
            end else if (RO_MASK[w_idx]) begin
               bresp_d = 2'b10;
            end else begin
               bresp_d           = 2'b00;
               conf_upd_d[w_idx] = 1'b1;
               for (int k = 0; k < STRB_W; k++) begin
                  if (w_strb_d[k]) conf_d[w_idx*DATA_W + k*8 +: 8] = w_data_d[k*8 +: 8];
               end
            end
         end
         W_RESP: if (m_bready_i) begin
            w_state_d = W_IDLE;
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      {r_hit, r_idx} = '0;
      case (r_state_q)
         // conf_view is pre-commit here, so a same-cycle write to the same register is not seen.
         R_IDLE: if (m_arvalid_i) begin
            r_state_d      = R_RESP;
            rid_d          = m_arid_i;
            {r_hit, r_idx} = decode(m_araddr_i);
            rdata_d        = r_hit ? conf_view[r_idx*DATA_W +: DATA_W] : '0;
            rresp_d        = r_hit ? 2'b00 : 2'b11;
         end
         R_RESP: if (m_rready_i) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         aw_full_q  <= 1'b0;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         w_full_q   <= 1'b0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         conf_q     <= {REG_NUM{CONF_RST}};
         conf_upd_q <= '0;
         bid_q      <= '0;
         bresp_q    <= '0;
         rid_q      <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         aw_full_q  <= aw_full_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         w_full_q   <= w_full_d;
         w_data_q   <= w_data_d;
         w_strb_q   <= w_strb_d;
         conf_q     <= conf_d;
         conf_upd_q <= conf_upd_d;
         bid_q      <= bid_d;
         bresp_q    <= bresp_d;
         rid_q      <= rid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign m_awready_o = !aw_full_q;
   assign m_wready_o  = !w_full_q;
   assign m_bvalid_o  = (w_state_q == W_RESP);
   assign m_bid_o     = bid_q;
   assign m_bresp_o   = bresp_q;
   assign m_arready_o = (r_state_q == R_IDLE);
   assign m_rvalid_o  = (r_state_q == R_RESP);
   assign m_rid_o     = rid_q;
   assign m_rdata_o   = rdata_q;
   assign m_rresp_o   = rresp_q;
   assign conf_o      = conf_view;
   assign conf_upd_o  = conf_upd_q;
endmodule
